stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline stall controller for the five-stage core. It decides each cycle which pipeline registers hold and where bubbles go. It detects load-use hazards that the register file's EX/MEM/WB bypass cannot cover, and sequences the multi-cycle divider in EX. It drives the stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- id_rs_re  in  1  ID instruction reads rs
- id_rs  in  5  rs address in ID
- id_rt_re  in  1  ID instruction reads rt
- id_rt  in  5  rt address in ID
- ex_to_id_bus  in  38  fields {we[37], waddr[36:32], result[31:0]}; only we/waddr used
- ex_is_load  in  1  EX holds a load (lb/lbu/lh/lhu/lw)
- ex_is_div  in  1  EX holds div/divu
- div_ready  in  1  divider result valid (one-cycle pulse)
- stall  out  6  hold vector {wb,mem,ex,id,if,pc} = bits 5..0
- ex_bubble  out  1  load ID/EX with a NOP this cycle
- div_start  out  1  one-cycle start pulse to divider
- stall_cycles  out  CNT_W  count of cycles with stall[0]=1

## Operation
- FSM states: RUN (reset state), DIV_WAIT.
- RUN, ex_is_div=1: div_start=1, stall=6'b001111, ex_bubble=0; next DIV_WAIT.
- RUN, ex_is_div=0, load-use hazard: stall=6'b000111, ex_bubble=1; stay RUN.
- Load-use hazard = ex_we & ex_is_load & (ex_waddr!=0) & ((id_rs_re & id_rs==ex_waddr) | (id_rt_re & id_rt==ex_waddr)).
- RUN, neither condition: stall=0, ex_bubble=0, div_start=0.
- DIV_WAIT, div_ready=0: stall=6'b001111 (EX and earlier hold; MEM receives a bubble because stall[3]=1 and stall[4]=0); div_start=0; stay.
- DIV_WAIT, div_ready=1: stall=0, so EX advances with the quotient/remainder; next RUN.
- The load-use check is not evaluated in DIV_WAIT, because ID is already held.
- ex_is_div and the load-use condition both true: the div path wins, and no ex_bubble is asserted.
- div_ready in RUN: ignored.
- Back-to-back divs: the second div reaches EX in RUN and restarts normally; there is no extra idle cycle.
- stall_cycles: +1 on every clock edge where stall[0]=1 and rst=0. Wraps from 2^CNT_W-1 to 0.
- stall[5] is always 0, because WB never holds.

## Timing
- stall, ex_bubble and div_start are combinational from the current inputs and the registered state, valid in the same cycle. State and the counter update on the rising clk edge.
- While rst=1: stall=0, ex_bubble=0, div_start=0 (forced). On the edge, state←RUN and stall_cycles←0.
- Load-use costs exactly 1 stall cycle. Once the bubble enters EX, the load is in MEM and the register-file MEM bypass supplies the data.
- Divide: div_start is asserted in cycle T. If div_ready arrives in cycle T+k (k≥1), the front end is stalled for k cycles (T..T+k-1) and released in T+k.
- Reset asserted in DIV_WAIT: next state is RUN and no div_start is issued during reset. The divider is reset by the same rst.

## Test plan
- Reset: assert rst for 2 cycles with ex_is_div=1 -> stall=0, div_start=0, stall_cycles=0. After release in RUN: div_start=1 and stall=6'h0F in the first cycle.
- Load-use: EX lw, ex_we=1, waddr=5; ID id_rs_re=1, id_rs=5 -> one cycle with stall=6'h07 and ex_bubble=1, then stall=0. Repeat with waddr=0 -> no stall. Repeat with id_rs_re=0 -> no stall.
- Divide: ex_is_div=1, div_ready pulses 33 cycles after div_start -> div_start high for exactly 1 cycle; stall=6'h0F for 33 cycles; stall=0 on the div_ready cycle; stall_cycles=33.
- Priority: ex_is_div=1, ex_is_load=1, and a matching rt -> div_start=1, ex_bubble=0, stall=6'h0F.
- Spurious/mid-op: div_ready in RUN -> no effect. rst asserted at DIV_WAIT cycle 10 -> stall=0 immediately; state RUN after the edge.
- Counter wrap (CNT_W=4): 17 stalled cycles -> stall_cycles reads 1.

Source files
------------

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//
// Pipeline stall controller for the five-stage core. It decides each cycle
// which pipeline registers hold and where bubbles are inserted. It handles two
// cases:
//   * Load-use hazards that the EX/MEM/WB bypass cannot cover. These cost
//     exactly one stall cycle and insert a NOP bubble into ID/EX.
//   * The multi-cycle divider in EX. The controller issues a one-cycle start
//     pulse and then holds the front end until the divider reports ready.
//
// Ports:
//   i_clk            core clock
//   i_rst            synchronous, active-high reset
//   i_id_rs_re       ID instruction reads rs
//   i_id_rs          rs address in ID
//   i_id_rt_re       ID instruction reads rt
//   i_id_rt          rt address in ID
//   i_ex_to_id_bus   {we[37], waddr[36:32], result[31:0]}; only we/waddr used
//   i_ex_is_load     EX holds a load
//   i_ex_is_div      EX holds div/divu
//   i_div_ready      divider result valid (one-cycle pulse)
//   o_stall          hold vector {wb,mem,ex,id,if,pc} = bits 5..0
//   o_ex_bubble      load ID/EX with a NOP this cycle
//   o_div_start      one-cycle start pulse to the divider
//   o_stall_cycles   count of cycles with o_stall[0]=1 (wraps)
//
// o_stall, o_ex_bubble and o_div_start are combinational from the current
// inputs and the registered state, because the pipeline registers must see
// them in the same cycle as the hazard.
// -----------------------------------------------------------------------------
module stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_rs_re,
    input  logic [4:0]       i_id_rs,
    input  logic             i_id_rt_re,
    input  logic [4:0]       i_id_rt,
    input  logic [37:0]      i_ex_to_id_bus,
    input  logic             i_ex_is_load,
    input  logic             i_ex_is_div,
    input  logic             i_div_ready,
    output logic [5:0]       o_stall,
    output logic             o_ex_bubble,
    output logic             o_div_start,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_WAIT = 1'b1
    } state_t;

    // Hold patterns: PC, IF/ID and ID/EX hold on a load-use hazard. The divide
    // wait additionally holds EX/MEM, so MEM receives a bubble.
    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [5:0] STALL_DIV      = 6'b001111;

    state_t            r_state;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic              w_ex_we;
    logic [4:0]        w_ex_waddr;
    logic              w_load_use;
    logic [5:0]        w_stall;
    logic              w_ex_bubble;
    logic              w_div_start;
    logic              w_unused_result;

    assign w_ex_we    = i_ex_to_id_bus[37];
    assign w_ex_waddr = i_ex_to_id_bus[36:32];

    // The result field is carried on the shared bus but does not affect stalls.
    assign w_unused_result = ^i_ex_to_id_bus[31:0];

    // Load-use detection: a load in EX writing a non-zero register that ID reads.
    assign w_load_use = w_ex_we & i_ex_is_load & (w_ex_waddr != 5'd0) &
                        ((i_id_rs_re & (i_id_rs == w_ex_waddr)) |
                         (i_id_rt_re & (i_id_rt == w_ex_waddr)));

    // Stall, bubble and divider-start decode for the current cycle.
    always_comb begin
        w_stall     = STALL_NONE;
        w_ex_bubble = 1'b0;
        w_div_start = 1'b0;
        if (i_rst) begin
            w_stall     = STALL_NONE;
            w_ex_bubble = 1'b0;
            w_div_start = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A divide takes priority over a load-use hazard; the held
                    // ID stage re-evaluates the hazard later.
                    if (i_ex_is_div) begin
                        w_stall     = STALL_DIV;
                        w_div_start = 1'b1;
                    end else if (w_load_use) begin
                        w_stall     = STALL_LOAD_USE;
                        w_ex_bubble = 1'b1;
                    end else begin
                        w_stall     = STALL_NONE;
                    end
                end
                ST_DIV_WAIT: begin
                    // ID is already held, so no load-use check here.
                    if (i_div_ready) begin
                        w_stall = STALL_NONE;
                    end else begin
                        w_stall = STALL_DIV;
                    end
                end
                default: begin
                    w_stall     = STALL_NONE;
                    w_ex_bubble = 1'b0;
                    w_div_start = 1'b0;
                end
            endcase
        end
    end

    // State register and stall-cycle performance counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_RUN;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_ex_is_div) begin
                        r_state <= ST_DIV_WAIT;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DIV_WAIT: begin
                    if (i_div_ready) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_DIV_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
            if (w_stall[0]) begin
                r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_stall        = w_stall;
    assign o_ex_bubble    = w_ex_bubble;
    assign o_div_start    = w_div_start;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for stall_ctrl. Two instances share all inputs: one with the
// default 32-bit counter and one with a 4-bit counter for the wrap case.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, and the counter is read after the rising edge it updates on.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_rs_re;
    logic [4:0]  id_rs;
    logic        id_rt_re;
    logic [4:0]  id_rt;
    logic [37:0] ex_to_id_bus;
    logic        ex_is_load;
    logic        ex_is_div;
    logic        div_ready;

    logic [5:0]  stall;
    logic        ex_bubble;
    logic        div_start;
    logic [31:0] stall_cycles;

    logic [5:0]  stall4;
    logic        ex_bubble4;
    logic        div_start4;
    logic [3:0]  stall_cycles4;

    int errors = 0;
    int checks = 0;

    logic [7:0] got;
    logic [7:0] exp_v;

    stall_ctrl #(.CNT_W(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_rs_re     (id_rs_re),
        .i_id_rs        (id_rs),
        .i_id_rt_re     (id_rt_re),
        .i_id_rt        (id_rt),
        .i_ex_to_id_bus (ex_to_id_bus),
        .i_ex_is_load   (ex_is_load),
        .i_ex_is_div    (ex_is_div),
        .i_div_ready    (div_ready),
        .o_stall        (stall),
        .o_ex_bubble    (ex_bubble),
        .o_div_start    (div_start),
        .o_stall_cycles (stall_cycles)
    );

    stall_ctrl #(.CNT_W(4)) dut4 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_rs_re     (id_rs_re),
        .i_id_rs        (id_rs),
        .i_id_rt_re     (id_rt_re),
        .i_id_rt        (id_rt),
        .i_ex_to_id_bus (ex_to_id_bus),
        .i_ex_is_load   (ex_is_load),
        .i_ex_is_div    (ex_is_div),
        .i_div_ready    (div_ready),
        .o_stall        (stall4),
        .o_ex_bubble    (ex_bubble4),
        .o_div_start    (div_start4),
        .o_stall_cycles (stall_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        id_rs_re     = 1'b0;
        id_rs        = 5'd0;
        id_rt_re     = 1'b0;
        id_rt        = 5'd0;
        ex_to_id_bus = 38'd0;
        ex_is_load   = 1'b0;
        ex_is_div    = 1'b0;
        div_ready    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        ex_is_div = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = {stall, ex_bubble, div_start}; exp_v = {6'h00, 1'b0, 1'b0};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %h expected %h", c, got, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counter: got %0d expected 0", stall_cycles);
        end
        rst = 1'b0;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h0F, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_release_div: got %h expected %h", got, exp_v);
        end
        // Finish the divide so the controller returns to RUN.
        @(negedge clk);
        div_ready = 1'b1;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_to_id_bus = {1'b1, 5'd5, 32'hDEAD_BEEF};
        ex_is_load   = 1'b1;
        id_rs_re     = 1'b1;
        id_rs        = 5'd5;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h07, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_rs: got %h expected %h", got, exp_v);
        end
        // Bubble now in EX; the load has moved on.
        @(negedge clk);
        ex_to_id_bus = 38'd0;
        ex_is_load   = 1'b0;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_release: got %h expected %h", got, exp_v);
        end
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
        // Destination r0 never hazards.
        @(negedge clk);
        ex_to_id_bus = {1'b1, 5'd0, 32'h0};
        ex_is_load   = 1'b1;
        id_rs_re     = 1'b1;
        id_rs        = 5'd0;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_r0: got %h expected %h", got, exp_v);
        end
        // rs not read.
        @(negedge clk);
        ex_to_id_bus = {1'b1, 5'd5, 32'h0};
        id_rs_re     = 1'b0;
        id_rs        = 5'd5;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_no_re: got %h expected %h", got, exp_v);
        end
        // Match through rt.
        @(negedge clk);
        ex_to_id_bus = {1'b1, 5'd9, 32'h0};
        id_rt_re     = 1'b1;
        id_rt        = 5'd9;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h07, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_rt: got %h expected %h", got, exp_v);
        end
        // Same match but EX not writing.
        @(negedge clk);
        ex_to_id_bus = {1'b0, 5'd9, 32'h0};
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_no_we: got %h expected %h", got, exp_v);
        end
        // Matching register but EX is not a load.
        @(negedge clk);
        ex_to_id_bus = {1'b1, 5'd9, 32'h0};
        ex_is_load   = 1'b0;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL load_use_not_load: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_divide();
        apply_reset();
        ex_is_div = 1'b1;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h0F, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL div_start_cycle: got %h expected %h", got, exp_v);
        end
        // Cycles T+1 .. T+32 wait with no start pulse.
        for (int k = 1; k < 33; k++) begin
            @(negedge clk);
            #1;
            got = {stall, ex_bubble, div_start}; exp_v = {6'h0F, 1'b0, 1'b0};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL div_wait k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        @(negedge clk);
        div_ready = 1'b1;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL div_ready_release: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 32'd33) begin
            errors++;
            $display("FAIL div_count: got %0d expected 33", stall_cycles);
        end
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL div_back_in_run: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        ex_is_div    = 1'b1;
        ex_is_load   = 1'b1;
        ex_to_id_bus = {1'b1, 5'd7, 32'h0};
        id_rt_re     = 1'b1;
        id_rt        = 5'd7;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h0F, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL priority_div_wins: got %h expected %h", got, exp_v);
        end
        // In DIV_WAIT the hazard stays ignored.
        @(negedge clk);
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h0F, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL priority_wait_no_bubble: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        div_ready = 1'b1;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        ex_is_div = 1'b1;
        @(negedge clk);
        div_ready = 1'b1;
        @(negedge clk);
        div_ready = 1'b0;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h0F, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL b2b_second_start: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        div_ready = 1'b1;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL b2b_second_release: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 32'd2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_spurious_and_mid_reset();
        apply_reset();
        div_ready = 1'b1;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL spurious_ready: got %h expected %h", got, exp_v);
        end
        // Still RUN: a load-use hazard must produce the RUN response.
        @(negedge clk);
        div_ready    = 1'b0;
        ex_to_id_bus = {1'b1, 5'd3, 32'h0};
        ex_is_load   = 1'b1;
        id_rs_re     = 1'b1;
        id_rs        = 5'd3;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = {6'h07, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL spurious_state_run: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        set_idle();
        ex_is_div = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected %h", got, exp_v);
        end
        @(negedge clk);
        rst       = 1'b0;
        ex_is_div = 1'b0;
        #1;
        got = {stall, ex_bubble, div_start}; exp_v = 8'h00;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_state_run: got %h expected %h", got, exp_v);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_counter: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        ex_is_div = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
        end
        div_ready = 1'b1;
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_cycles4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cnt4: got %0d expected 1", stall_cycles4);
        end
        checks++;
        if (stall_cycles !== 32'd17) begin
            errors++;
            $display("FAIL wrap_cnt32: got %0d expected 17", stall_cycles);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_divide();
        test_priority();
        test_back_to_back();
        test_spurious_and_mid_reset();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
